// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Brief    : Shared FFT constants, the complex sample type and the
//             bin-index bit reversal helper.
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N_LOG2 = 4;
    localparam int FFT_N      = 1 << FFT_N_LOG2;
    localparam int FFT_OUT_W  = 23;

    // One complex FFT output sample, real part in the upper half
    typedef struct packed {
        logic signed [FFT_OUT_W-1:0] re;
        logic signed [FFT_OUT_W-1:0] im;
    } fft_sample_t;

    // Mirror the index bits: bit i moves to bit FFT_N_LOG2-1-i
    function automatic logic [FFT_N_LOG2-1:0] bitrev(input logic [FFT_N_LOG2-1:0] idx);
        logic [FFT_N_LOG2-1:0] r;
        for (int i = 0; i < FFT_N_LOG2; i++) begin
            r[i] = idx[FFT_N_LOG2-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_bank_ram
//  Brief    : Simple dual-port register array holding both ping-pong banks.
//             Address MSB selects the bank. One synchronous write port, one
//             synchronous read port with registered read data.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_bank_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 46
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [c_DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Storage array: written only on qualified writes, never reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read data register holds its value between reads
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // Read register clears on reset so the data outputs start at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bitrev_reorder
//  Brief    : Ping-pong reorder buffer after the 16-point SDF FFT. Frames
//             arrive in bit-reversed bin order and are written with
//             bit-reversed addresses; the previous frame streams out in
//             natural bin order with sof/eof markers.
//  Revision : 1.0  initial release
// ============================================================================
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_OUT_W,
    parameter int N_LOG2 = FFT_N_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] data_re_i,
    input  logic signed [DATA_W-1:0] data_im_i,
    input  logic                     valid_i,
    output logic signed [DATA_W-1:0] data_re_o,
    output logic signed [DATA_W-1:0] data_im_o,
    output logic                     valid_o,
    output logic [N_LOG2-1:0]        bin_o,
    output logic                     sof_o,
    output logic                     eof_o
);

    localparam int                c_ADDR_W   = N_LOG2 + 1;
    localparam logic [N_LOG2-1:0] c_LAST_IDX = '1;
    localparam logic [N_LOG2-1:0] c_ONE      = N_LOG2'(1);

    // Write side state
    logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    // Read side state
    logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_bank_q, rd_bank_d;
    // One full flag per bank: set when a frame lands, cleared when drained
    logic [1:0]        full_q, full_d;
    // Registered output markers
    logic [N_LOG2-1:0] bin_q, bin_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;

    // RAM port signals
    logic                  rd_en;
    logic [c_ADDR_W-1:0]   wr_addr;
    logic [c_ADDR_W-1:0]   rd_addr;
    logic [2*DATA_W-1:0]   wr_data;
    logic [2*DATA_W-1:0]   rd_data;

    assign wr_addr = {wr_bank_q, bitrev(wr_cnt_q)};
    assign wr_data = {data_re_i, data_im_i};
    assign rd_en   = full_q[rd_bank_q];
    assign rd_addr = {rd_bank_q, rd_cnt_q};

    // Next-state: write counter/bank, read counter/bank, full flags, markers
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        bin_d     = bin_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;

        if (valid_i) begin
            wr_cnt_d = wr_cnt_q + c_ONE;
            if (wr_cnt_q == c_LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Banks alternate, so this clear never targets the bank set above
        if (rd_en) begin
            valid_d  = 1'b1;
            bin_d    = rd_cnt_q;
            sof_d    = (rd_cnt_q == '0);
            eof_d    = (rd_cnt_q == c_LAST_IDX);
            rd_cnt_d = rd_cnt_q + c_ONE;
            if (rd_cnt_q == c_LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    // State and output registers; reset drops any partial frame or readout
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            bin_q     <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            bin_q     <= bin_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
        end
    end

    reorder_bank_ram #(
        .ADDR_W (c_ADDR_W),
        .DATA_W (2*DATA_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (valid_i),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign data_re_o = rd_data[2*DATA_W-1:DATA_W];
    assign data_im_o = rd_data[DATA_W-1:0];
    assign valid_o   = valid_q;
    assign bin_o     = bin_q;
    assign sof_o     = sof_q;
    assign eof_o     = eof_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_bitrev_reorder
//  Brief    : Scoreboard bench for fft_bitrev_reorder. Accepted samples are
//             gathered into frames; each complete frame is permuted into
//             natural order with its expected output edge and queued. A
//             monitor compares every cycle against the queue head.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int W = FFT_OUT_W;
    localparam int N = FFT_N;

    typedef struct {
        fft_sample_t s;
        int          bin;
        int          cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] data_re_i = '0;
    logic signed [W-1:0] data_im_i = '0;
    logic                valid_i = 1'b0;
    logic signed [W-1:0] data_re_o;
    logic signed [W-1:0] data_im_o;
    logic                valid_o;
    logic [FFT_N_LOG2-1:0] bin_o;
    logic                sof_o;
    logic                eof_o;

    int checks  = 0;
    int errors  = 0;
    int edge_n  = 0;
    int last_end = 0;
    bit started = 1'b0;

    fft_sample_t frame[$];
    exp_t        exp_q[$];

    fft_bitrev_reorder #(.DATA_W(W), .N_LOG2(FFT_N_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_re_i (data_re_i),
        .data_im_i (data_im_i),
        .valid_i   (valid_i),
        .data_re_o (data_re_o),
        .data_im_o (data_im_o),
        .valid_o   (valid_o),
        .bin_o     (bin_o),
        .sof_o     (sof_o),
        .eof_o     (eof_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Natural bin b receives the sample that arrived at position rev(b)
    function automatic int rev4(input int b);
        int r = 0;
        for (int i = 0; i < FFT_N_LOG2; i++) begin
            if (((b >> i) & 1) != 0) r = r + (1 << (FFT_N_LOG2 - 1 - i));
        end
        return r;
    endfunction

    task automatic schedule_frame();
        int start;
        start = edge_n + 1;
        if (start <= last_end) start = last_end + 1;
        for (int b = 0; b < N; b++) begin
            exp_t e;
            e.s   = frame[rev4(b)];
            e.bin = b;
            e.cyc = start + b;
            exp_q.push_back(e);
        end
        last_end = start + N - 1;
        frame.delete();
    endtask

    task automatic drive(input bit v, input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        fft_sample_t s;
        valid_i   = v;
        data_re_i = re;
        data_im_i = im;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        if (v) begin
            s.re = re;
            s.im = im;
            frame.push_back(s);
            if (frame.size() == N) schedule_frame();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst     = 1'b1;
        valid_i = 1'b0;
        exp_q.delete();
        frame.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_end = edge_n;
        started  = 1'b1;
        checks++;
        if ({valid_o, sof_o, eof_o, bin_o, data_re_o, data_im_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b sof=%b eof=%b bin=%0d re=%0d im=%0d, want all zero",
                     valid_o, sof_o, eof_o, bin_o, data_re_o, data_im_o);
        end
    endtask

    task automatic send_frame(input int base, input bit gapped);
        for (int k = 0; k < N; k++) begin
            drive(1'b1, W'(base + k), W'(-(base + k)));
            if (gapped) drive(1'b0, '0, '0);
        end
    endtask

    // Monitor: every cycle, valid_o must match whether the queue head is due
    always @(negedge clk) begin
        if (started) begin
            bit   exp_v;
            exp_t e;
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == edge_n);
            checks++;
            if (valid_o !== exp_v) begin
                errors++;
                $display("FAIL valid_o at edge %0d: got %b, want %b", edge_n, valid_o, exp_v);
            end
            if (exp_v) begin
                e = exp_q.pop_front();
                checks++;
                if (data_re_o !== e.s.re || data_im_o !== e.s.im || int'(bin_o) != e.bin ||
                    sof_o !== (e.bin == 0) || eof_o !== (e.bin == N-1)) begin
                    errors++;
                    $display("FAIL sample bin %0d: got re=%0d im=%0d bin=%0d sof=%b eof=%b, want re=%0d im=%0d bin=%0d sof=%b eof=%b",
                             e.bin, data_re_o, data_im_o, bin_o, sof_o, eof_o,
                             e.s.re, e.s.im, e.bin, (e.bin == 0), (e.bin == N-1));
                end
            end
        end
    end

    // A frame must never complete into a bank that is still waiting to drain
    always @(posedge clk) begin
        if (started && !rst && valid_i && dut.wr_cnt_q == 4'hF) begin
            checks++;
            if (dut.full_q[dut.wr_bank_q]) begin
                errors++;
                $display("FAIL overflow: got write into full bank %0d, want bank empty", dut.wr_bank_q);
            end
        end
    end

    initial begin
        do_reset();
        idle(3);

        // Single gap-free frame re=k, im=-k
        send_frame(0, 1'b0);
        idle(20);

        // Two frames back to back; second offset by 100
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        idle(20);

        // Gapped frame
        send_frame(0, 1'b1);
        idle(20);

        // Extreme values at arrival index 1
        for (int k = 0; k < N; k++) begin
            if (k == 1) drive(1'b1, 23'h3FFFFF, 23'h400000);
            else        drive(1'b1, W'($urandom), W'($urandom));
        end
        idle(20);

        // Reset after a partial frame, then a full frame
        for (int k = 0; k < 7; k++) drive(1'b1, W'(500 + k), W'(-(500 + k)));
        do_reset();
        idle(2);
        send_frame(200, 1'b0);
        idle(20);

        // Reset during readout once bin 5 has been presented
        send_frame(300, 1'b0);
        idle(6);
        do_reset();
        idle(20);
        send_frame(400, 1'b0);
        idle(20);

        // Random data with random input gaps
        for (int f = 0; f < 6; f++) begin
            int got = 0;
            while (got < N) begin
                bit v;
                v = ($urandom_range(0, 9) < 7);
                drive(v, W'($urandom), W'($urandom));
                if (v) got++;
            end
        end
        idle(40);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d samples never output, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
